axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI3 read arbiter: round-robin grant of a single outstanding
// burst onto a shared AR/R channel, with sticky beat-count protocol error flag.
module axi_rd_arbiter #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] S0_ARID    = 4'd0,
    parameter logic [3:0] S1_ARID    = 4'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_arvalid,
    input  logic [31:0]           s0_araddr,
    input  logic [3:0]            s0_arlen,
    output logic                  s0_arready,
    output logic                  s0_rvalid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic                  s0_rlast,
    input  logic                  s0_rready,
    input  logic                  s1_arvalid,
    input  logic [31:0]           s1_araddr,
    input  logic [3:0]            s1_arlen,
    output logic                  s1_arready,
    output logic                  s1_rvalid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic                  s1_rlast,
    input  logic                  s1_rready,
    output logic                  m_arvalid,
    output logic [31:0]           m_araddr,
    output logic [3:0]            m_arlen,
    output logic [3:0]            m_arid,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rlast,
    output logic                  m_rready,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_r;
    logic        owner_r;
    logic        last_grant_r;
    logic [3:0]  beat_cnt_r;
    logic        m_arvalid_r;
    logic [31:0] m_araddr_r;
    logic [3:0]  m_arlen_r;
    logic [3:0]  m_arid_r;
    logic        proto_err_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        in_data_s;
    logic        m_rready_s;
    logic        r_hs_s;

    // Round-robin grant, only offered while idle and out of reset
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (s0_arvalid && s1_arvalid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (s0_arvalid) begin
                grant0_s = 1'b1;
            end else if (s1_arvalid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // R-channel routing to the burst owner; nothing passes outside DATA
    always_comb begin
        in_data_s  = (state_r == ST_DATA);
        m_rready_s = 1'b0;
        if (in_data_s) begin
            if (owner_r) begin
                m_rready_s = s1_rready;
            end else begin
                m_rready_s = s0_rready;
            end
        end else begin
            m_rready_s = 1'b0;
        end
        r_hs_s = m_rvalid && m_rready_s;
    end

    assign s0_arready = grant0_s;
    assign s1_arready = grant1_s;
    assign s0_rvalid  = in_data_s && !owner_r && m_rvalid;
    assign s0_rlast   = in_data_s && !owner_r && m_rlast;
    assign s1_rvalid  = in_data_s && owner_r && m_rvalid;
    assign s1_rlast   = in_data_s && owner_r && m_rlast;
    assign s0_rdata   = m_rdata;
    assign s1_rdata   = m_rdata;
    assign m_rready   = m_rready_s;
    assign m_arvalid  = m_arvalid_r;
    assign m_araddr   = m_araddr_r;
    assign m_arlen    = m_arlen_r;
    assign m_arid     = m_arid_r;
    assign m_arsize   = 3'b010;
    assign m_arburst  = 2'b01;
    assign proto_err  = proto_err_r;

    // Burst FSM: capture request, present AR, count beats until rlast
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            beat_cnt_r   <= 4'd0;
            m_arvalid_r  <= 1'b0;
            m_araddr_r   <= 32'd0;
            m_arlen_r    <= 4'd0;
            m_arid_r     <= 4'd0;
            proto_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        state_r      <= ST_ADDR;
                        owner_r      <= grant1_s;
                        last_grant_r <= grant1_s;
                        beat_cnt_r   <= 4'd0;
                        m_arvalid_r  <= 1'b1;
                        m_araddr_r   <= grant1_s ? s1_araddr : s0_araddr;
                        m_arlen_r    <= grant1_s ? s1_arlen : s0_arlen;
                        m_arid_r     <= grant1_s ? S1_ARID : S0_ARID;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid_r <= 1'b0;
                        state_r     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs_s) begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                        if (m_rlast) begin
                            state_r <= ST_IDLE;
                            if (beat_cnt_r != m_arlen_r) begin
                                proto_err_r <= 1'b1;
                            end
                        end else if (beat_cnt_r == m_arlen_r) begin
                            // Final beat arrived without rlast: flag it, wait for rlast
                            proto_err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    m_arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    axi_rd_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data_s),
        .s0_arready(grant0_s),
        .s1_arready(grant1_s),
        .s0_rvalid (s0_rvalid),
        .s1_rvalid (s1_rvalid),
        .m_rready  (m_rready_s),
        .m_arvalid (m_arvalid_r),
        .m_arready (m_arready),
        .m_araddr  (m_araddr_r)
    );

endmodule

// Invariant checker for the arbiter handshakes.
module axi_rd_arbiter_chk (
    input logic        clk,
    input logic        rst,
    input logic        in_data,
    input logic        s0_arready,
    input logic        s1_arready,
    input logic        s0_rvalid,
    input logic        s1_rvalid,
    input logic        m_rready,
    input logic        m_arvalid,
    input logic        m_arready,
    input logic [31:0] m_araddr
);

    logic        stall_r;
    logic [31:0] addr_r;

    // Remember a pending, unaccepted AR so its stability can be checked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_r <= 1'b0;
            addr_r  <= 32'd0;
        end else begin
            stall_r <= m_arvalid && !m_arready;
            addr_r  <= m_araddr;
        end
    end

    // Handshake invariants sampled on every active edge
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(s0_arready && s1_arready));
            assert (!(s0_rvalid && s1_rvalid));
            assert (in_data || (!m_rready && !s0_rvalid && !s1_rvalid));
            assert (!stall_r || (m_arvalid && (m_araddr == addr_r)));
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with AR and R scoreboards.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_arvalid, s1_arvalid;
    logic [31:0] s0_araddr, s1_araddr;
    logic [3:0]  s0_arlen, s1_arlen;
    logic        s0_arready, s1_arready;
    logic        s0_rvalid, s1_rvalid;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_rlast, s1_rlast;
    logic        s0_rready, s1_rready;
    logic        m_arvalid;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen, m_arid;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rlast;
    logic        m_rready;
    logic        proto_err;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
    } ar_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        last;
    } r_t;

    ar_t        ar_q[$];
    r_t         r_q[$];
    int         total;
    int         bad;
    bit         model_last;
    bit         pe_model;
    logic [3:0] cnt_model;
    int         win;
    logic [3:0] wlen;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arready(s0_arready), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
        .s0_rlast(s0_rlast), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arready(s1_arready), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
        .s1_rlast(s1_rlast), .s1_rready(s1_rready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rready(m_rready), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop scoreboards on handshakes visible this cycle
    task automatic observe();
        ar_t a;
        r_t  r;
        if (m_arvalid && m_arready) begin
            chk("ar_pending", ar_q.size() > 0, 1);
            if (ar_q.size() > 0) begin
                a = ar_q.pop_front();
                chk("m_arid", m_arid, a.id);
                chk("m_araddr", m_araddr, a.addr);
                chk("m_arlen", m_arlen, a.len);
            end
        end
        if (s0_rvalid && s0_rready) begin
            chk("r_pending0", r_q.size() > 0, 1);
            if (r_q.size() > 0) begin
                r = r_q.pop_front();
                chk("r_port0", 0, r.port);
                chk("s0_rdata", s0_rdata, r.data);
                chk("s0_rlast", s0_rlast, r.last);
            end
        end
        if (s1_rvalid && s1_rready) begin
            chk("r_pending1", r_q.size() > 0, 1);
            if (r_q.size() > 0) begin
                r = r_q.pop_front();
                chk("r_port1", 1, r.port);
                chk("s1_rdata", s1_rdata, r.data);
                chk("s1_rlast", s1_rlast, r.last);
            end
        end
    endtask

    // Request cycle, optional AR stall, then AR handshake
    task automatic issue(input bit r0, input bit r1, input logic [31:0] a0, input logic [3:0] l0,
                         input logic [31:0] a1, input logic [3:0] l1, input int stall,
                         output int w, output logic [3:0] wl);
        ar_t e;
        @(negedge clk);
        s0_arvalid = r0; s0_araddr = a0; s0_arlen = l0;
        s1_arvalid = r1; s1_araddr = a1; s1_arlen = l1;
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        s0_rready = 1'b1; s1_rready = 1'b1;
        #1;
        if (r0 && r1) w = model_last ? 0 : 1;
        else w = r1 ? 1 : 0;
        model_last = (w == 1);
        e.id   = (w == 1) ? 4'd1 : 4'd0;
        e.addr = (w == 1) ? a1 : a0;
        e.len  = (w == 1) ? l1 : l0;
        wl = e.len;
        chk("s0_arready_grant", s0_arready, w == 0);
        chk("s1_arready_grant", s1_arready, w == 1);
        chk("idle_m_rready", m_rready, 0);
        chk("idle_rvalid", {s0_rvalid, s1_rvalid}, 0);
        chk("idle_m_arvalid", m_arvalid, 0);
        chk("proto_err_idle", proto_err, pe_model);
        ar_q.push_back(e);
        cnt_model = 4'd0;
        observe();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            s0_arvalid = 1'b1; s1_arvalid = 1'b1;
            s0_araddr = ~a0; s1_araddr = ~a1;
            m_arready = 1'b0; m_rvalid = 1'b1;
            #1;
            chk("stall_m_arvalid", m_arvalid, 1);
            chk("stall_m_araddr", m_araddr, e.addr);
            chk("stall_arready", {s0_arready, s1_arready}, 0);
            chk("addr_m_rready", m_rready, 0);
            chk("addr_rvalid", {s0_rvalid, s1_rvalid}, 0);
            observe();
        end
        @(negedge clk);
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("hs_m_arvalid", m_arvalid, 1);
        chk("addr_arready", {s0_arready, s1_arready}, 0);
        observe();
    endtask

    // Drive beats; rready of the owner optionally toggles 1,0,1,0
    task automatic data(input int port, input logic [3:0] len, input int nbeats,
                        input bit final_last, input bit toggle);
        bit rr;
        bit hs;
        r_t e;
        rr = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            e.port = port;
            e.data = $urandom;
            e.last = final_last && (b == nbeats - 1);
            r_q.push_back(e);
            hs = 1'b0;
            while (!hs) begin
                @(negedge clk);
                m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = e.data; m_rlast = e.last;
                s0_rready = (port == 0) ? rr : 1'b1;
                s1_rready = (port == 1) ? rr : 1'b1;
                #1;
                chk("m_rready_mirror", m_rready, rr);
                chk("owner_rvalid", (port == 0) ? s0_rvalid : s1_rvalid, 1);
                chk("other_rvalid", (port == 0) ? s1_rvalid : s0_rvalid, 0);
                chk("proto_err_data", proto_err, pe_model);
                observe();
                hs = rr;
                if (hs) begin
                    if (e.last) begin
                        if (cnt_model != len) pe_model = 1'b1;
                    end else if (cnt_model == len) begin
                        pe_model = 1'b1;
                    end
                    cnt_model = cnt_model + 4'd1;
                end
                if (toggle) rr = !rr;
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        model_last = 1'b1; pe_model = 1'b0; cnt_model = 4'd0;
        rst = 1'b1;
        s0_arvalid = 1'b1; s0_araddr = 32'h1234; s0_arlen = 4'd2;
        s1_arvalid = 1'b1; s1_araddr = 32'h5678; s1_arlen = 4'd2;
        s0_rready = 1'b1; s1_rready = 1'b1;
        m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'd0; m_rlast = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arready", {s0_arready, s1_arready}, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("m_arsize", m_arsize, 3'b010);
        chk("m_arburst", m_arburst, 2'b01);
        @(negedge clk);
        rst = 1'b0; s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b0;

        // Simultaneous requests alternate s0,s1,s0,s1
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 1'b1, 32'h1000 + k, 4'd1, 32'h2000 + k, 4'd1, 0, win, wlen);
            chk("rr_order", win, k % 2);
            data(win, wlen, 2, 1'b1, 1'b0);
        end

        // s0 boot fetch, 8 beats
        issue(1'b1, 1'b0, 32'hbfc00000, 4'd7, 32'd0, 4'd0, 0, win, wlen);
        data(0, 4'd7, 8, 1'b1, 1'b0);

        // AR held off for 5 cycles
        issue(1'b0, 1'b1, 32'd0, 4'd0, 32'h8000_0040, 4'd0, 5, win, wlen);
        data(1, 4'd0, 1, 1'b1, 1'b0);

        // s1 burst with toggling rready
        issue(1'b0, 1'b1, 32'd0, 4'd0, 32'h8000_0100, 4'd3, 0, win, wlen);
        data(1, 4'd3, 4, 1'b1, 1'b1);

        // Early rlast: error is sticky, next burst still serviced
        issue(1'b1, 1'b0, 32'h0000_0200, 4'd3, 32'd0, 4'd0, 0, win, wlen);
        data(0, 4'd3, 2, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 32'd0, 4'd0, 32'h0000_0300, 4'd1, 0, win, wlen);
        data(1, 4'd1, 2, 1'b1, 1'b0);

        // Reset mid-DATA on beat 2 of 8
        issue(1'b1, 1'b0, 32'h0000_0400, 4'd7, 32'd0, 4'd0, 0, win, wlen);
        data(0, 4'd7, 2, 1'b0, 1'b0);
        @(negedge clk);
        m_rvalid = 1'b1; m_rdata = 32'hdead_beef; m_rlast = 1'b0; s0_rready = 1'b1;
        #1;
        chk("pre_rst_s0_rvalid", s0_rvalid, 1);
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_s0_rvalid", s0_rvalid, 0);
        chk("arst_m_rready", m_rready, 0);
        chk("arst_arready", {s0_arready, s1_arready}, 0);
        chk("arst_m_arvalid", m_arvalid, 0);
        chk("arst_m_araddr", m_araddr, 0);
        chk("arst_m_arlen", m_arlen, 0);
        chk("arst_m_arid", m_arid, 0);
        chk("arst_proto_err", proto_err, 0);
        @(negedge clk);
        rst = 1'b0; s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b0;
        model_last = 1'b1; pe_model = 1'b0;

        // Round-robin pointer restarts favouring s0, then a lone s1 request
        issue(1'b1, 1'b1, 32'h0000_0500, 4'd0, 32'h0000_0600, 4'd0, 0, win, wlen);
        chk("post_rst_winner", win, 0);
        data(win, wlen, 1, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 32'd0, 4'd0, 32'h0000_0700, 4'd2, 0, win, wlen);
        data(1, 4'd2, 3, 1'b1, 1'b0);

        // Missing rlast on final beat: error, stay in DATA until rlast
        issue(1'b0, 1'b1, 32'd0, 4'd0, 32'h0000_0800, 4'd1, 0, win, wlen);
        data(1, 4'd1, 3, 1'b1, 1'b0);

        @(negedge clk);
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        chk("final_idle_m_rready", m_rready, 0);
        chk("final_idle_rvalid", {s0_rvalid, s1_rvalid}, 0);
        chk("final_proto_err", proto_err, pe_model);
        chk("ar_q_drained", ar_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
